test_card_sequencer: RTL and testbench
======================================

TEST_CARD_SEQUENCER -- requirements
Module: test_card_sequencer

Interface
REQ-001 SHALL have parameter H_RES, default 640: active pixels per line.
REQ-002 SHALL have parameter NUM_PATTERNS, default 4: test patterns cycled, 2..8.
REQ-003 SHALL have parameter HOLD_FRAMES, default 60: frames each pattern is shown in auto mode, >=1.
REQ-004 SHALL have port i_clk, input, 1: pixel-domain clock.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_pix_stb, input, 1: pixel clock enable; all timing inputs are qualified by it.
REQ-007 SHALL have port i_frame, input, 1: start-of-frame strobe.
REQ-008 SHALL have port i_line, input, 1: start-of-line strobe.
REQ-009 SHALL have port i_de, input, 1: active-video data enable.
REQ-010 SHALL have port i_req_valid, input, 1: host pattern request valid.
REQ-011 SHALL have port i_req_pattern, input, 3: requested pattern index.
REQ-012 SHALL have port i_req_auto, input, 1: request auto-cycle mode (i_req_pattern then ignored).
REQ-013 SHALL have port o_req_ready, output, 1: request accepted when high with i_req_valid.
REQ-014 SHALL have port o_x, output, signed 16: horizontal position feeding the colour-band generator.
REQ-015 SHALL have port o_pattern, output, 3: current pattern index.
REQ-016 SHALL have port o_pattern_stb, output, 1: one-cycle pulse when o_pattern changes.

Function
REQ-017 SHALL run states AUTO, MANUAL and PENDING; PENDING holds the accepted target pattern and target mode.
REQ-018 SHALL drive o_req_ready = 1 in AUTO and MANUAL and 0 in PENDING.
REQ-019 SHALL, on i_req_valid & o_req_ready, latch the request and enter PENDING on the next clock.
REQ-020 SHALL clamp a requested index >= NUM_PATTERNS to NUM_PATTERNS-1.
REQ-021 SHALL define a frame event as i_frame & i_pix_stb; all pattern changes occur only at frame events.
REQ-022 SHALL, in PENDING at a frame event, load the target (AUTO target: keep the current pattern), enter the target mode and clear the frame counter.
REQ-023 SHALL treat a request accepted in the same cycle as a frame event as pending until the following frame event.
REQ-024 SHALL, in AUTO, count frame events 0..HOLD_FRAMES-1; on the frame event at count HOLD_FRAMES-1, advance o_pattern by 1, wrap NUM_PATTERNS-1 to 0, and clear the count.
REQ-025 SHALL, in MANUAL, hold o_pattern and the frame counter.
REQ-026 SHALL pulse o_pattern_stb for exactly one clock, aligned with the o_pattern update, only if the value changes.
REQ-027 SHALL register o_x and update it only on i_pix_stb: i_line sets 0; otherwise i_de advances by 1, saturating at H_RES-1; !i_de holds.
REQ-028 SHALL give i_line priority over i_de in the same strobe, with o_x valid one clock after the strobe.
REQ-029 SHALL ignore i_frame, i_line and i_de when i_pix_stb is low.

Reset
REQ-030 SHALL, while i_rst_n is low, force state AUTO, o_pattern 0, o_pattern_stb 0, o_x 0, frame counter 0 and the pending registers 0, with o_req_ready 1.
REQ-031 SHALL discard a request pending at reset assertion; no pattern change follows reset release.
REQ-032 SHALL take reset release synchronously to i_clk, via an external synchroniser.

Structure
REQ-033 SHALL place the state encodings (AUTO=0, MANUAL=1, PENDING=2) and the pattern-index width in shared package test_card_pkg.
REQ-034 SHALL implement the o_x counter as sub-module line_position_counter (parameter H_RES).
REQ-035 SHALL size the frame counter as $clog2(HOLD_FRAMES)+1 bits, with no other parameter-dependent widths.

Verification
REQ-036 SHALL cover: reset release, HOLD_FRAMES=2, NUM_PATTERNS=4, 9 frame events -> o_pattern 0,0,1,1,2,2,3,3,0, with 4 stb pulses.
REQ-037 SHALL cover: MANUAL request pattern 5 with NUM_PATTERNS=4 -> o_req_ready low until the next frame event, then o_pattern=3, state MANUAL.
REQ-038 SHALL cover: request valid in the same cycle as a frame event -> no change at that frame, change at the next frame.
REQ-039 SHALL cover: line of 700 strobes with i_de high, H_RES=640 -> o_x goes 0..639 and holds 639; i_line returns it to 0.
REQ-040 SHALL cover: request pattern equal to current -> no o_pattern_stb; assert i_rst_n low while PENDING -> all outputs are reset values and no change at the next frame.

Source files
------------

// File: rtl/test_card_pkg.sv
// Shared definitions for the test card sequencer.
// Contents:
//   PAT_W   - width of a pattern index
//   pat_t   - pattern index type
//   state_e - sequencer state encoding (AUTO=0, MANUAL=1, PENDING=2)
package test_card_pkg;

    localparam int PAT_W = 3;

    typedef logic [PAT_W-1:0] pat_t;

    typedef enum logic [1:0] {
        ST_AUTO    = 2'd0,
        ST_MANUAL  = 2'd1,
        ST_PENDING = 2'd2
    } state_e;

endpackage

// File: rtl/line_position_counter.sv
// Horizontal position counter for the colour-band generator.
// Ports:
//   i_clk, i_rst_n - pixel clock, asynchronous active-low reset
//   i_pix_stb      - pixel enable; i_line and i_de are only looked at when high
//   i_line         - start-of-line strobe, returns the position to 0
//   i_de           - active video, advances the position by one
//   o_x            - registered position, saturates at H_RES-1
module line_position_counter #(
    parameter int H_RES = 640
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_stb,
    input  logic               i_line,
    input  logic               i_de,
    output logic signed [15:0] o_x
);

    localparam logic signed [15:0] X_MAX = 16'(H_RES - 1);

    logic signed [15:0] x_q;
    logic signed [15:0] x_d;

    // Increment that sticks at the last active pixel so an overlong line
    // never runs the band generator off the right edge.
    function automatic logic signed [15:0] sat_inc(input logic signed [15:0] x);
        if (x >= X_MAX) begin
            return X_MAX;
        end
        return x + 16'sd1;
    endfunction

    always_comb begin
        x_d = x_q;
        if (i_pix_stb) begin
            // Start of line wins over data enable in the same strobe.
            if (i_line) begin
                x_d = 16'sd0;
            end else if (i_de) begin
                x_d = sat_inc(x_q);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_q <= 16'sd0;
        end else begin
            x_q <= x_d;
        end
    end

    assign o_x = x_q;

endmodule

// File: rtl/test_card_sequencer.sv
// Test card pattern sequencer.
// Cycles through NUM_PATTERNS test patterns, holding each for HOLD_FRAMES
// frames (AUTO), or holds a host-selected pattern (MANUAL). Host requests
// are parked in PENDING and take effect on the next frame event so the
// picture never changes mid-frame.
// Ports:
//   i_clk, i_rst_n          - pixel clock, asynchronous active-low reset
//   i_pix_stb               - pixel enable qualifying i_frame/i_line/i_de
//   i_frame, i_line, i_de   - video timing strobes
//   i_req_valid/o_req_ready - host request handshake
//   i_req_pattern           - requested pattern (clamped to the last pattern)
//   i_req_auto              - request auto-cycle mode instead of a pattern
//   o_x                     - horizontal position for the band generator
//   o_pattern               - current pattern index
//   o_pattern_stb           - one-cycle pulse when o_pattern changes
module test_card_sequencer
    import test_card_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int NUM_PATTERNS = 4,
    parameter int HOLD_FRAMES  = 60
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_stb,
    input  logic               i_frame,
    input  logic               i_line,
    input  logic               i_de,
    input  logic               i_req_valid,
    input  logic [PAT_W-1:0]   i_req_pattern,
    input  logic               i_req_auto,
    output logic               o_req_ready,
    output logic signed [15:0] o_x,
    output logic [PAT_W-1:0]   o_pattern,
    output logic               o_pattern_stb
);

    localparam int                CNT_W    = $clog2(HOLD_FRAMES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam pat_t              PAT_LAST = PAT_W'(NUM_PATTERNS - 1);

    state_e           state_q, state_d;
    pat_t             pattern_q, pattern_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pat_t             tgt_pat_q, tgt_pat_d;
    logic             tgt_auto_q, tgt_auto_d;
    logic             stb_q;

    logic frame_evt;
    logic accept;

    function automatic pat_t clamp_pat(input pat_t p);
        if (int'(p) >= NUM_PATTERNS) begin
            return PAT_LAST;
        end
        return p;
    endfunction

    assign frame_evt = i_frame & i_pix_stb;
    assign accept    = i_req_valid & o_req_ready;

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_AUTO;
            pattern_q  <= '0;
            cnt_q      <= '0;
            tgt_pat_q  <= '0;
            tgt_auto_q <= 1'b0;
            stb_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pattern_q  <= pattern_d;
            cnt_q      <= cnt_d;
            tgt_pat_q  <= tgt_pat_d;
            tgt_auto_q <= tgt_auto_d;
            // Pulse lines up with the register update and only fires on a
            // real change (a MANUAL request for the current pattern is silent).
            stb_q      <= (pattern_d != pattern_q);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        pattern_d  = pattern_q;
        cnt_d      = cnt_q;
        tgt_pat_d  = tgt_pat_q;
        tgt_auto_d = tgt_auto_q;

        case (state_q)
            ST_AUTO: begin
                if (frame_evt) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        pattern_d = (pattern_q == PAT_LAST) ? '0 : pattern_q + PAT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // A request accepted on a frame event only takes effect at
                // the following frame event, since PENDING starts next cycle.
                if (accept) begin
                    state_d    = ST_PENDING;
                    tgt_pat_d  = clamp_pat(i_req_pattern);
                    tgt_auto_d = i_req_auto;
                end
            end
            ST_MANUAL: begin
                if (accept) begin
                    state_d    = ST_PENDING;
                    tgt_pat_d  = clamp_pat(i_req_pattern);
                    tgt_auto_d = i_req_auto;
                end
            end
            ST_PENDING: begin
                if (frame_evt) begin
                    cnt_d = '0;
                    if (tgt_auto_q) begin
                        // Auto resumes from whatever is on screen now.
                        state_d = ST_AUTO;
                    end else begin
                        state_d   = ST_MANUAL;
                        pattern_d = tgt_pat_q;
                    end
                end
            end
            default: begin
                state_d = ST_AUTO;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        o_req_ready = (state_q != ST_PENDING);
    end

    assign o_pattern     = pattern_q;
    assign o_pattern_stb = stb_q;

    line_position_counter #(
        .H_RES (H_RES)
    ) u_line_pos (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_pix_stb (i_pix_stb),
        .i_line    (i_line),
        .i_de      (i_de),
        .o_x       (o_x)
    );

endmodule

// File: tb/tb_test_card_sequencer.sv
module tb_test_card_sequencer;
    import test_card_pkg::*;

    localparam int H_RES        = 640;
    localparam int NUM_PATTERNS = 4;
    localparam int HOLD_FRAMES  = 2;

    logic               clk;
    logic               rst_n;
    logic               pix_stb;
    logic               frame;
    logic               line;
    logic               de;
    logic               req_valid;
    logic [2:0]         req_pattern;
    logic               req_auto;
    logic               req_ready;
    logic signed [15:0] x;
    logic [2:0]         pattern;
    logic               pattern_stb;

    int passed = 0;
    int total  = 0;

    test_card_sequencer #(
        .H_RES        (H_RES),
        .NUM_PATTERNS (NUM_PATTERNS),
        .HOLD_FRAMES  (HOLD_FRAMES)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pix_stb     (pix_stb),
        .i_frame       (frame),
        .i_line        (line),
        .i_de          (de),
        .i_req_valid   (req_valid),
        .i_req_pattern (req_pattern),
        .i_req_auto    (req_auto),
        .o_req_ready   (req_ready),
        .o_x           (x),
        .o_pattern     (pattern),
        .o_pattern_stb (pattern_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       stb;
        logic       frm;
        logic       lin;
        logic       de;
        logic       rv;
        logic [2:0] rp;
        logic       ra;
        int         ex;
        int         ep;
        logic       es;
        logic       er;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic l, input logic d,
                         input logic rv, input logic [2:0] rp, input logic ra);
        pix_stb     = s;
        frame       = f;
        line        = l;
        de          = d;
        req_valid   = rv;
        req_pattern = rp;
        req_auto    = ra;
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    int exp36[9];
    int stb_count;
    int exp_x;

    initial begin
        rst_n = 1'b0;
        idle();

        // stb, frame, line, de, rv, rp, ra,   x, pattern, stb, ready
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 0, 0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1, 0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1, 0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 2, 0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 0, 0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1, 0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1, 0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 2, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 2, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1, 2, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 2, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1, 1, 1'b1, 1'b1};

        exp36 = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

        // Reset state while held in reset.
        cycle();
        check("rst_x", int'(x), 0);
        check("rst_pattern", int'(pattern), 0);
        check("rst_stb", int'(pattern_stb), 0);
        check("rst_ready", int'(req_ready), 1);
        check("rst_state", int'(dut.state_q), int'(ST_AUTO));
        rst_n = 1'b1;
        cycle();

        // Table-driven vectors.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].stb, vecs[i].frm, vecs[i].lin, vecs[i].de,
                  vecs[i].rv, vecs[i].rp, vecs[i].ra);
            cycle();
            check($sformatf("vec%0d_x", i), int'(x), vecs[i].ex);
            check($sformatf("vec%0d_pattern", i), int'(pattern), vecs[i].ep);
            check($sformatf("vec%0d_stb", i), int'(pattern_stb), int'(vecs[i].es));
            check($sformatf("vec%0d_ready", i), int'(req_ready), int'(vecs[i].er));
        end
        idle();

        // Auto cycling from reset: pattern shown during each of 9 frames.
        do_reset();
        stb_count = 0;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("auto_frame%0d", i), int'(pattern), exp36[i]);
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
            cycle();
            if (pattern_stb) stb_count++;
            idle();
            cycle();
            if (pattern_stb) stb_count++;
        end
        check("auto_stb_count", stb_count, 4);
        check("auto_final_pattern", int'(pattern), 0);

        // Manual request above range is clamped and waits for a frame.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        cycle();
        check("clamp_ready_low", int'(req_ready), 0);
        idle();
        cycle();
        cycle();
        check("clamp_ready_still_low", int'(req_ready), 0);
        check("clamp_pattern_held", int'(pattern), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle();
        check("clamp_pattern", int'(pattern), 3);
        check("clamp_stb", int'(pattern_stb), 1);
        check("clamp_ready", int'(req_ready), 1);
        check("clamp_state", int'(dut.state_q), int'(ST_MANUAL));
        stb_count = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
            cycle();
            if (pattern_stb) stb_count++;
            idle();
            cycle();
        end
        check("manual_hold_pattern", int'(pattern), 3);
        check("manual_hold_stb", stb_count, 0);

        // Request equal to the current pattern: no strobe.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        cycle();
        check("same_ready_low", int'(req_ready), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle();
        check("same_pattern", int'(pattern), 3);
        check("same_stb", int'(pattern_stb), 0);
        check("same_ready", int'(req_ready), 1);

        // Request on the same cycle as a frame event waits one more frame.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
        cycle();
        check("coinc_ready_low", int'(req_ready), 0);
        check("coinc_pattern", int'(pattern), 3);
        check("coinc_stb", int'(pattern_stb), 0);
        idle();
        cycle();
        check("coinc_idle_pattern", int'(pattern), 3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle();
        check("coinc_next_pattern", int'(pattern), 1);
        check("coinc_next_stb", int'(pattern_stb), 1);

        // Return to auto: keep current pattern, restart the hold count.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1);
        cycle();
        check("to_auto_ready_low", int'(req_ready), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle();
        check("to_auto_pattern", int'(pattern), 1);
        check("to_auto_stb", int'(pattern_stb), 0);
        check("to_auto_state", int'(dut.state_q), int'(ST_AUTO));
        cycle();
        check("to_auto_frame1", int'(pattern), 1);
        cycle();
        check("to_auto_frame2", int'(pattern), 2);
        check("to_auto_frame2_stb", int'(pattern_stb), 1);

        // Line position: saturation over a 700-pixel line, then line restart.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle();
        check("line_start_x", int'(x), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 700; i++) begin
            cycle();
            exp_x = (i + 1 > H_RES - 1) ? H_RES - 1 : i + 1;
            check($sformatf("line_x%0d", i), int'(x), exp_x);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
        cycle();
        check("line_restart_x", int'(x), 0);

        // Reset while a request is pending discards it.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        cycle();
        check("pre_rst_x", int'(x), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        cycle();
        check("pre_rst_ready_low", int'(req_ready), 0);
        check("pre_rst_pattern", int'(pattern), 2);
        idle();
        rst_n = 1'b0;
        #1;
        check("async_rst_pattern", int'(pattern), 0);
        check("async_rst_stb", int'(pattern_stb), 0);
        check("async_rst_x", int'(x), 0);
        check("async_rst_ready", int'(req_ready), 1);
        check("async_rst_state", int'(dut.state_q), int'(ST_AUTO));
        cycle();
        rst_n = 1'b1;
        cycle();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        cycle();
        check("post_rst_pattern", int'(pattern), 0);
        check("post_rst_stb", int'(pattern_stb), 0);
        check("post_rst_ready", int'(req_ready), 1);
        idle();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
